// File: rtl/bmem_arb_pkg.sv
// Shared types and constants for the burst-memory arbiter.
package bmem_arb_pkg;

  localparam int unsigned BEAT_BITS        = 64;
  localparam int unsigned LINE_BITS        = 256;
  localparam int unsigned LINE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRdCmd,
    StRdData,
    StWrData,
    StDone
  } bmem_arb_state_t;

  // Clear the byte-within-line offset of a byte address.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/bmem_arbiter_rr_arbiter.sv
// Request arbiter for bmem_arbiter. Round-robin from a pointer by default;
// fixed lowest-index priority when BMEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  input  logic [IdxW-1:0]   cur_grant_i,
  output logic [NumReq-1:0] gnt_onehot_o,
  output logic [IdxW-1:0]   gnt_idx_o
);

`ifdef BMEM_ARB_FIXED_PRIO_EN

  // Lowest pending index wins.
  always_comb begin
    logic found;
    found        = 1'b0;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_i[i]) begin
        found           = 1'b1;
        gnt_onehot_o[i] = 1'b1;
        gnt_idx_o       = IdxW'(i);
      end
    end
  end

  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_i, advance_i, cur_grant_i};

`else

  logic [IdxW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps modulo NumReq.
  always_comb begin
    logic        found;
    int unsigned cand;
    found        = 1'b0;
    cand         = 0;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(ptr_q) + i) % NumReq;
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found                         = 1'b1;
        gnt_onehot_o[cand[IdxW-1:0]]  = 1'b1;
        gnt_idx_o                     = cand[IdxW-1:0];
      end
    end
  end

  // Pointer moves past the completed grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (32'(cur_grant_i) == NumReq - 1) ? '0 : cur_grant_i + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/bmem_arbiter.sv
// Serialises whole-line requests from NUM_REQ requesters onto one burst
// memory port. Optional macro: BMEM_ARB_FIXED_PRIO_EN (fixed priority).
module bmem_arbiter
  import bmem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*32-1:0]            req_addr,
  input  logic [NUM_REQ*BEAT_BITS*LINE_BEATS-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [BEAT_BITS*LINE_BEATS-1:0]  resp_rdata,
  output logic [31:0]                      bmem_addr,
  output logic                             bmem_read,
  output logic                             bmem_write,
  output logic [BEAT_BITS-1:0]             bmem_wdata,
  input  logic                             bmem_ready,
  input  logic [31:0]                      bmem_raddr,
  input  logic [BEAT_BITS-1:0]             bmem_rdata,
  input  logic                             bmem_rvalid
);

  localparam int unsigned LineW = BEAT_BITS * LINE_BEATS;
  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(LINE_BEATS - 1);

  bmem_arb_state_t    state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [31:0]        addr_q, addr_d;
  logic [LineW-1:0]   wdata_q, wdata_d;
  logic [LineW-1:0]   line_q, line_d;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [IdxW-1:0]    arb_idx;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req_valid),
    .advance_i    (state_q == StDone),
    .cur_grant_i  (grant_q),
    .gnt_onehot_o (arb_onehot),
    .gnt_idx_o    (arb_idx)
  );

  // Transaction sequencing and line assembly.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    unique case (state_q)
      StIdle: begin
        if (|arb_onehot) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_onehot;
          addr_d     = line_addr(req_addr[32'(arb_idx)*32 +: 32]);
          wdata_d    = req_wdata[32'(arb_idx)*LineW +: LineW];
          cnt_d      = '0;
          state_d    = req_write[arb_idx] ? StWrData : StRdCmd;
        end
      end
      // Beats returned in the command cycle are not accepted.
      StRdCmd: begin
        if (bmem_ready) state_d = StRdData;
      end
      StRdData: begin
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          line_d[32'(cnt_q)*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StDone;
        end
      end
      StWrData: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StDone;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bmem_read  = (state_q == StRdCmd);
    bmem_write = (state_q == StWrData);
    bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
    bmem_wdata = bmem_write ? wdata_q[32'(cnt_q)*BEAT_BITS +: BEAT_BITS] : '0;
    resp_valid = (state_q == StDone) ? grant_oh_q : '0;
    resp_rdata = line_q;
  end

endmodule
